// File: rtl/ptw_mem_arbiter.sv
// Page-table-walker memory arbiter: shares one read port between the
// ITLB and DTLB walkers with round-robin grant and a read timeout.
module ptw_mem_arbiter #(
   parameter int ADDR_WIDTH     = 64,
   parameter int DATA_WIDTH     = 64,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  itlb_req_valid_i,
   input  logic [ADDR_WIDTH-1:0] itlb_req_addr_i,
   output logic                  itlb_resp_valid_o,
   output logic [DATA_WIDTH-1:0] itlb_resp_data_o,
   output logic                  itlb_resp_err_o,
   input  logic                  dtlb_req_valid_i,
   input  logic [ADDR_WIDTH-1:0] dtlb_req_addr_i,
   output logic                  dtlb_resp_valid_o,
   output logic [DATA_WIDTH-1:0] dtlb_resp_data_o,
   output logic                  dtlb_resp_err_o,
   output logic                  mem_arvalid_o,
   output logic [ADDR_WIDTH-1:0] mem_araddr_o,
   input  logic                  mem_arready_i,
   input  logic                  mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
   input  logic                  mem_rerr_i,
   output logic                  busy_o,
   output logic                  overrun_o
);

   localparam int CW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_RESP,
      S_DRAIN
   } state_e;

   state_e                state_q;
   logic                  pend_i_q;
   logic                  pend_d_q;
   logic [ADDR_WIDTH-1:0] slot_i_q;
   logic [ADDR_WIDTH-1:0] slot_d_q;
   logic                  last_d_q;
   logic                  own_d_q;
   logic                  timed_out_q;
   logic [CW-1:0]         cnt_q;
   logic                  arvalid_q;
   logic [ADDR_WIDTH-1:0] araddr_q;
   logic                  i_valid_q;
   logic [DATA_WIDTH-1:0] i_data_q;
   logic                  i_err_q;
   logic                  d_valid_q;
   logic [DATA_WIDTH-1:0] d_data_q;
   logic                  d_err_q;
   logic                  overrun_q;

   logic                  active;
   logic                  drop_i;
   logic                  drop_d;
   logic                  cand_i;
   logic                  cand_d;
   logic                  gnt_d;
   logic [ADDR_WIDTH-1:0] gnt_addr;

   // Owner of the port in flight, pulse-drop detection and tie-break.
   assign active = (state_q == S_ADDR) | (state_q == S_DATA)
                 | (state_q == S_DRAIN);
   assign drop_i = itlb_req_valid_i & (pend_i_q | (active & ~own_d_q));
   assign drop_d = dtlb_req_valid_i & (pend_d_q | (active & own_d_q));
   assign cand_i = pend_i_q | itlb_req_valid_i;
   assign cand_d = pend_d_q | dtlb_req_valid_i;
   assign gnt_d  = cand_d & (~cand_i | ~last_d_q);
   assign gnt_addr = gnt_d
                   ? (pend_d_q ? slot_d_q : dtlb_req_addr_i)
                   : (pend_i_q ? slot_i_q : itlb_req_addr_i);

   // Request capture plus the arbitration / memory-read state machine.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         pend_i_q    <= 1'b0;
         pend_d_q    <= 1'b0;
         slot_i_q    <= '0;
         slot_d_q    <= '0;
         last_d_q    <= 1'b1;
         own_d_q     <= 1'b0;
         timed_out_q <= 1'b0;
         cnt_q       <= '0;
         arvalid_q   <= 1'b0;
         araddr_q    <= '0;
         i_valid_q   <= 1'b0;
         i_data_q    <= '0;
         i_err_q     <= 1'b0;
         d_valid_q   <= 1'b0;
         d_data_q    <= '0;
         d_err_q     <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         i_valid_q <= 1'b0;
         d_valid_q <= 1'b0;
         if (itlb_req_valid_i) begin
            if (drop_i) begin
               overrun_q <= 1'b1;
            end else begin
               pend_i_q <= 1'b1;
               slot_i_q <= itlb_req_addr_i;
            end
         end
         if (dtlb_req_valid_i) begin
            if (drop_d) begin
               overrun_q <= 1'b1;
            end else begin
               pend_d_q <= 1'b1;
               slot_d_q <= dtlb_req_addr_i;
            end
         end
         case (state_q)
            S_IDLE: begin
               if (cand_i | cand_d) begin
                  arvalid_q <= 1'b1;
                  araddr_q  <= gnt_addr;
                  own_d_q   <= gnt_d;
                  last_d_q  <= gnt_d;
                  if (gnt_d) pend_d_q <= 1'b0;
                  else       pend_i_q <= 1'b0;
                  state_q   <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (mem_arready_i) begin
                  arvalid_q <= 1'b0;
                  cnt_q     <= '0;
                  state_q   <= S_DATA;
               end
            end
            S_DATA: begin
               if (mem_rvalid_i) begin
                  if (own_d_q) begin
                     d_valid_q <= 1'b1;
                     d_data_q  <= mem_rdata_i;
                     d_err_q   <= mem_rerr_i;
                  end else begin
                     i_valid_q <= 1'b1;
                     i_data_q  <= mem_rdata_i;
                     i_err_q   <= mem_rerr_i;
                  end
                  state_q <= S_RESP;
               end else if (cnt_q == CNT_LAST) begin
                  if (own_d_q) begin
                     d_valid_q <= 1'b1;
                     d_data_q  <= '0;
                     d_err_q   <= 1'b1;
                  end else begin
                     i_valid_q <= 1'b1;
                     i_data_q  <= '0;
                     i_err_q   <= 1'b1;
                  end
                  timed_out_q <= 1'b1;
                  state_q     <= S_RESP;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_RESP: begin
               state_q <= timed_out_q ? S_DRAIN : S_IDLE;
            end
            S_DRAIN: begin
               if (mem_rvalid_i) begin
                  timed_out_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign itlb_resp_valid_o = i_valid_q;
   assign itlb_resp_data_o  = i_data_q;
   assign itlb_resp_err_o   = i_err_q;
   assign dtlb_resp_valid_o = d_valid_q;
   assign dtlb_resp_data_o  = d_data_q;
   assign dtlb_resp_err_o   = d_err_q;
   assign mem_arvalid_o     = arvalid_q;
   assign mem_araddr_o      = araddr_q;
   assign busy_o            = (state_q != S_IDLE) | pend_i_q | pend_d_q;
   assign overrun_o         = overrun_q;

endmodule

// File: tb/tb_ptw_mem_arbiter.sv
// Directed bench for ptw_mem_arbiter: grant order, stalls, timeout,
// errors, overrun and reset behaviour, with a short timeout.
module tb_ptw_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        itlb_req_valid = 1'b0;
   logic [63:0] itlb_req_addr = '0;
   logic        itlb_resp_valid;
   logic [63:0] itlb_resp_data;
   logic        itlb_resp_err;
   logic        dtlb_req_valid = 1'b0;
   logic [63:0] dtlb_req_addr = '0;
   logic        dtlb_resp_valid;
   logic [63:0] dtlb_resp_data;
   logic        dtlb_resp_err;
   logic        mem_arvalid;
   logic [63:0] mem_araddr;
   logic        mem_arready = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [63:0] mem_rdata = '0;
   logic        mem_rerr = 1'b0;
   logic        busy;
   logic        overrun;

   int n_chk  = 0;
   int n_pass = 0;
   int lat;

   ptw_mem_arbiter #(
      .ADDR_WIDTH     (64),
      .DATA_WIDTH     (64),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .itlb_req_valid_i  (itlb_req_valid),
      .itlb_req_addr_i   (itlb_req_addr),
      .itlb_resp_valid_o (itlb_resp_valid),
      .itlb_resp_data_o  (itlb_resp_data),
      .itlb_resp_err_o   (itlb_resp_err),
      .dtlb_req_valid_i  (dtlb_req_valid),
      .dtlb_req_addr_i   (dtlb_req_addr),
      .dtlb_resp_valid_o (dtlb_resp_valid),
      .dtlb_resp_data_o  (dtlb_resp_data),
      .dtlb_resp_err_o   (dtlb_resp_err),
      .mem_arvalid_o     (mem_arvalid),
      .mem_araddr_o      (mem_araddr),
      .mem_arready_i     (mem_arready),
      .mem_rvalid_i      (mem_rvalid),
      .mem_rdata_i       (mem_rdata),
      .mem_rerr_i        (mem_rerr),
      .busy_o            (busy),
      .overrun_o         (overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic wait_ar(input string tag, input logic [63:0] ea,
                          output int l);
      l = 0;
      do begin
         tick();
         l++;
         itlb_req_valid = 1'b0;
         dtlb_req_valid = 1'b0;
      end while (!mem_arvalid && l < 20);
      chk({tag, "_arvalid"}, 64'(mem_arvalid), 64'd1);
      chk({tag, "_araddr"}, mem_araddr, ea);
   endtask

   task automatic complete(input string tag, input logic own_d,
                           input logic [63:0] rd, input logic re,
                           input int dly);
      mem_arready = 1'b1;
      tick();
      chk({tag, "_ar_lo"}, 64'(mem_arvalid), 64'd0);
      repeat (dly) tick();
      mem_rvalid = 1'b1;
      mem_rdata  = rd;
      mem_rerr   = re;
      tick();
      mem_rvalid = 1'b0;
      mem_rerr   = 1'b0;
      chk({tag, "_ivalid"}, 64'(itlb_resp_valid), 64'(!own_d));
      chk({tag, "_dvalid"}, 64'(dtlb_resp_valid), 64'(own_d));
      if (own_d) begin
         chk({tag, "_data"}, dtlb_resp_data, rd);
         chk({tag, "_err"}, 64'(dtlb_resp_err), 64'(re));
      end else begin
         chk({tag, "_data"}, itlb_resp_data, rd);
         chk({tag, "_err"}, 64'(itlb_resp_err), 64'(re));
      end
      tick();
      chk({tag, "_pulse_end"},
          64'(itlb_resp_valid | dtlb_resp_valid), 64'd0);
   endtask

   initial begin
      tick();
      tick();
      chk("rst_arvalid", 64'(mem_arvalid), 64'd0);
      chk("rst_araddr", mem_araddr, 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_overrun", 64'(overrun), 64'd0);
      chk("rst_resp", 64'(itlb_resp_valid | dtlb_resp_valid), 64'd0);
      rst = 1'b0;
      tick();

      // single ITLB read, data three cycles into DATA
      mem_arready    = 1'b1;
      itlb_req_valid = 1'b1;
      itlb_req_addr  = 64'h8000_1000;
      wait_ar("t1", 64'h8000_1000, lat);
      chk("t1_latency", 64'(lat), 64'd1);
      complete("t1", 1'b0, 64'h2000_00CF, 1'b0, 2);
      chk("t1_busy", 64'(busy), 64'd0);

      // tie after an ITLB grant: DTLB first, then ITLB
      itlb_req_valid = 1'b1;
      itlb_req_addr  = 64'hA000;
      dtlb_req_valid = 1'b1;
      dtlb_req_addr  = 64'hB000;
      wait_ar("t2a_d", 64'hB000, lat);
      complete("t2a_d", 1'b1, 64'h22, 1'b0, 0);
      wait_ar("t2a_i", 64'hA000, lat);
      complete("t2a_i", 1'b0, 64'h11, 1'b0, 0);

      // address stall longer than the timeout: no timeout in ADDR
      mem_arready    = 1'b0;
      dtlb_req_valid = 1'b1;
      dtlb_req_addr  = 64'hC000;
      wait_ar("t3", 64'hC000, lat);
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("t3_hold_v", 64'(mem_arvalid), 64'd1);
         chk("t3_hold_a", mem_araddr, 64'hC000);
      end
      chk("t3_no_resp", 64'(dtlb_resp_valid), 64'd0);
      complete("t3", 1'b1, 64'h33, 1'b0, 1);

      // timeout, drain of the late beat, then queued DTLB
      mem_arready    = 1'b1;
      itlb_req_valid = 1'b1;
      itlb_req_addr  = 64'hD000;
      wait_ar("t4", 64'hD000, lat);
      tick();
      chk("t4_ar_lo", 64'(mem_arvalid), 64'd0);
      dtlb_req_valid = 1'b1;
      dtlb_req_addr  = 64'hE000;
      for (int k = 0; k < 8; k++) begin
         chk("t4_no_early", 64'(itlb_resp_valid), 64'd0);
         tick();
         dtlb_req_valid = 1'b0;
      end
      chk("t4_to_valid", 64'(itlb_resp_valid), 64'd1);
      chk("t4_to_err", 64'(itlb_resp_err), 64'd1);
      chk("t4_to_data", itlb_resp_data, 64'd0);
      chk("t4_to_dv", 64'(dtlb_resp_valid), 64'd0);
      tick();
      chk("t4_drain_v", 64'(itlb_resp_valid), 64'd0);
      chk("t4_drain_busy", 64'(busy), 64'd1);
      tick();
      tick();
      chk("t4_drain_noar", 64'(mem_arvalid), 64'd0);
      mem_rvalid = 1'b1;
      mem_rdata  = 64'hBAD;
      tick();
      mem_rvalid = 1'b0;
      chk("t4_late_noar", 64'(mem_arvalid), 64'd0);
      chk("t4_late_nore",
          64'(itlb_resp_valid | dtlb_resp_valid), 64'd0);
      chk("t4_hold_err", 64'(itlb_resp_err), 64'd1);
      chk("t4_hold_data", itlb_resp_data, 64'd0);
      wait_ar("t4_d", 64'hE000, lat);
      chk("t4_d_latency", 64'(lat), 64'd1);
      complete("t4_d", 1'b1, 64'h44, 1'b0, 0);

      // bus error routed only to the owner
      itlb_req_valid = 1'b1;
      itlb_req_addr  = 64'hF000;
      wait_ar("t5e", 64'hF000, lat);
      complete("t5e", 1'b0, 64'h55, 1'b1, 0);

      // second DTLB pulse while pending is dropped and sticks
      mem_arready    = 1'b0;
      itlb_req_valid = 1'b1;
      itlb_req_addr  = 64'h7000;
      wait_ar("t5i", 64'h7000, lat);
      dtlb_req_valid = 1'b1;
      dtlb_req_addr  = 64'h7100;
      tick();
      chk("t5_ovr_before", 64'(overrun), 64'd0);
      dtlb_req_addr  = 64'h7200;
      tick();
      dtlb_req_valid = 1'b0;
      chk("t5_ovr_set", 64'(overrun), 64'd1);
      chk("t5_stall_addr", mem_araddr, 64'h7000);
      complete("t5i", 1'b0, 64'h66, 1'b0, 0);
      wait_ar("t5d", 64'h7100, lat);
      complete("t5d", 1'b1, 64'h77, 1'b0, 0);
      chk("t5_ovr_sticky", 64'(overrun), 64'd1);

      // after reset ITLB wins the first tie
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t2b_ovr_clr", 64'(overrun), 64'd0);
      tick();
      itlb_req_valid = 1'b1;
      itlb_req_addr  = 64'h1000;
      dtlb_req_valid = 1'b1;
      dtlb_req_addr  = 64'h2000;
      wait_ar("t2b_i", 64'h1000, lat);
      complete("t2b_i", 1'b0, 64'h1111, 1'b0, 0);
      wait_ar("t2b_d", 64'h2000, lat);
      complete("t2b_d", 1'b1, 64'h2222, 1'b0, 0);

      // reset in DATA clears everything; stray beat ignored
      itlb_req_valid = 1'b1;
      itlb_req_addr  = 64'h9000;
      wait_ar("t6", 64'h9000, lat);
      tick();
      rst = 1'b1;
      #1;
      chk("t6_rst_ar", 64'(mem_arvalid), 64'd0);
      chk("t6_rst_addr", mem_araddr, 64'd0);
      chk("t6_rst_busy", 64'(busy), 64'd0);
      chk("t6_rst_idata", itlb_resp_data, 64'd0);
      chk("t6_rst_ddata", dtlb_resp_data, 64'd0);
      tick();
      rst = 1'b0;
      tick();
      mem_rvalid = 1'b1;
      mem_rdata  = 64'h99;
      tick();
      mem_rvalid = 1'b0;
      chk("t6_stray_i", 64'(itlb_resp_valid), 64'd0);
      chk("t6_stray_d", 64'(dtlb_resp_valid), 64'd0);
      chk("t6_stray_data", itlb_resp_data, 64'd0);
      chk("t6_stray_busy", 64'(busy), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
